id_ex_decode: RTL

Decode stage and ID/EX pipeline register for the pipelined RV32I core. It drives the existing execute-stage ALU. Each cycle it takes the fetched instruction and the register-file read data, then produces the 4-bit ALU control code, the ALU operands, the branch condition select, the jump target and the memory and writeback controls. Everything is registered into the EX stage, with stall and flush handling.

---
 rtl/id_ex_decode.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/id_ex_decode.sv
// id_ex_decode: RV32I decode stage feeding a registered ID/EX pipeline stage with stall and flush
module id_ex_decode (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic        stall,
  input  logic        flush,
  output logic        ex_valid,
  output logic [3:0]  ex_alu_control,
  output logic [31:0] ex_op_a,
  output logic [31:0] ex_op_b,
  output logic [31:0] ex_rs2_data,
  output logic [31:0] ex_target,
  output logic [2:0]  ex_branch_cond,
  output logic        ex_jump,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic [2:0]  ex_mem_funct3,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_write,
  output logic        ex_illegal
);
  localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, AND = 4'b0010, OR = 4'b0011, XOR = 4'b0100;
  localparam logic [3:0] SLL = 4'b0101, SRL = 4'b0110, SRA = 4'b0111, SLT = 4'b1000, SLTU = 4'b1001;
  typedef struct packed {
    logic        valid;
    logic [3:0]  alu;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] rs2;
    logic [31:0] target;
    logic [2:0]  bc;
    logic        jump;
    logic        mr;
    logic        mw;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
  } ex_t;
  ex_t dec, ex_d, ex_q;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm, shamt, jalr_sum;
  assign opcode   = id_instr[6:0];
  assign funct3   = id_instr[14:12];
  assign funct7   = id_instr[31:25];
  assign i_imm    = {{20{id_instr[31]}}, id_instr[31:20]};
  assign s_imm    = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
  assign b_imm    = {{19{id_instr[31]}}, id_instr[31], id_instr[7], id_instr[30:25], id_instr[11:8], 1'b0};
  assign u_imm    = {id_instr[31:12], 12'b0};
  assign j_imm    = {{11{id_instr[31]}}, id_instr[31], id_instr[19:12], id_instr[20], id_instr[30:21], 1'b0};
  assign shamt    = {27'b0, id_instr[24:20]};
  assign jalr_sum = id_rs1_data + i_imm;
  function automatic logic [3:0] alu_of(input logic [2:0] f);
    return f == 3'b000 ? ADD : f == 3'b001 ? SLL : f == 3'b010 ? SLT : f == 3'b011 ? SLTU :
           f == 3'b100 ? XOR : f == 3'b101 ? SRL : f == 3'b110 ? OR : AND;
  endfunction
  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    dec.op_a  = id_rs1_data;
    dec.op_b  = i_imm;
    dec.rs2   = id_rs2_data;
    dec.rd    = id_instr[11:7];
    case (opcode)
      7'b0110011: begin
        dec.op_b = id_rs2_data;
        dec.rw   = 1'b1;
        dec.alu  = funct7 == 7'b0000000 ? alu_of(funct3) : funct3 == 3'b000 ? SUB : SRA;
        dec.ill  = !(funct7 == 7'b0000000 || (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
      end
      7'b0010011: begin
        dec.rw = 1'b1;
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec.op_b = shamt;
          dec.alu  = funct3 == 3'b001 ? SLL : funct7 == 7'b0100000 ? SRA : SRL;
          dec.ill  = !(funct7 == 7'b0000000 || (funct3 == 3'b101 && funct7 == 7'b0100000));
        end else begin
          dec.alu = alu_of(funct3);
        end
      end
      7'b0000011: begin
        dec.mr  = 1'b1;
        dec.rw  = 1'b1;
        dec.f3  = funct3;
        dec.ill = funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111;
      end
      7'b0100011: begin
        dec.op_b = s_imm;
        dec.mw   = 1'b1;
        dec.f3   = funct3;
        dec.ill  = funct3[2] || funct3 == 3'b011;
      end
      7'b1100011: begin
        dec.alu    = SUB;
        dec.op_b   = id_rs2_data;
        dec.target = id_pc + b_imm;
        dec.bc     = funct3 == 3'b000 ? 3'd1 : funct3 == 3'b001 ? 3'd2 : funct3 == 3'b100 ? 3'd3 :
                     funct3 == 3'b101 ? 3'd4 : funct3 == 3'b110 ? 3'd5 : funct3 == 3'b111 ? 3'd6 : 3'd0;
        dec.ill    = funct3 == 3'b010 || funct3 == 3'b011;
      end
      7'b0110111: begin
        dec.op_a = '0;
        dec.op_b = u_imm;
        dec.rw   = 1'b1;
      end
      7'b0010111: begin
        dec.op_a = id_pc;
        dec.op_b = u_imm;
        dec.rw   = 1'b1;
      end
      7'b1101111: begin
        dec.op_a   = id_pc;
        dec.op_b   = 32'd4;
        dec.target = id_pc + j_imm;
        dec.jump   = 1'b1;
        dec.rw     = 1'b1;
      end
      7'b1100111: begin
        dec.op_a   = id_pc;
        dec.op_b   = 32'd4;
        dec.target = {jalr_sum[31:1], 1'b0};
        dec.jump   = 1'b1;
        dec.rw     = 1'b1;
        dec.ill    = funct3 != 3'b000;
      end
      default: dec.ill = 1'b1;
    endcase
    if (dec.ill) begin
      dec.rw   = 1'b0;
      dec.mr   = 1'b0;
      dec.mw   = 1'b0;
      dec.jump = 1'b0;
      dec.bc   = 3'd0;
    end
    if (dec.rd == 5'd0) dec.rw = 1'b0;
  end
  always_comb ex_d = flush ? '0 : stall ? ex_q : id_valid ? dec : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ex_q <= '0;
    else ex_q <= ex_d;
  assign ex_valid       = ex_q.valid;
  assign ex_alu_control = ex_q.alu;
  assign ex_op_a        = ex_q.op_a;
  assign ex_op_b        = ex_q.op_b;
  assign ex_rs2_data    = ex_q.rs2;
  assign ex_target      = ex_q.target;
  assign ex_branch_cond = ex_q.bc;
  assign ex_jump        = ex_q.jump;
  assign ex_mem_read    = ex_q.mr;
  assign ex_mem_write   = ex_q.mw;
  assign ex_mem_funct3  = ex_q.f3;
  assign ex_rd          = ex_q.rd;
  assign ex_reg_write   = ex_q.rw;
  assign ex_illegal     = ex_q.ill;
endmodule
